seg7_scan: RTL and testbench
============================

# seg7_scan

Four-digit, time-multiplexed seven-segment scan driver that sits directly downstream of the message-rotation stage. It takes that stage's 16-bit `dataBus` (four hex nibbles) and drives the board's common-anode display. It snapshots the input once per refresh frame so a rotation step never tears mid-frame, and inserts a dark gap between digits to suppress ghosting. It runs on the fast board clock, not the 3 Hz rotation clock.

## Interface
- `DIGIT_CYC`, 50000: clock cycles each digit is lit per frame; must be ≥1.
- `GAP_CYC`, 500: dark (all-anodes-off) cycles before each digit; must be ≥1.
- `clk`  in  1  board clock; all state changes on its rising edge.
- `clr`  in  1  reset; asynchronous, active-low.
- `data`  in  16  four hex digits; `data[3:0]` is the rightmost digit (digit 0), `data[15:12]` the leftmost (digit 3).
- `dp_in`  in  4  decimal-point request per digit; bit i belongs to digit i; 1 = point on.
- `lz_blank`  in  1  1 = blank leading zeros.
- `an`  out  4  anode enables, active-low; bit i drives digit i.
- `seg`  out  7  segments, active-low; `seg[0]`=a … `seg[6]`=g.
- `dp`  out  1  decimal point, active-low.
- `frame_start`  out  1  one-cycle pulse, one cycle after each frame snapshot.

## Operation
- State registers: `state` ∈ {GAP, SHOW}, digit index `idx` (2 bits), cycle counter `cnt` (width `$clog2(max(DIGIT_CYC, GAP_CYC))`), snapshot registers `snap[15:0]`, `snap_dp[3:0]` and `snap_lz`.
- Reset values: `state`=GAP, `idx`=0, `cnt`=0, all snapshots 0, `frame_start`=0. Outputs at reset: `an`=4'b1111, `seg`=7'h7F, `dp`=1.
- GAP: `cnt` counts 0..GAP_CYC-1. At GAP_CYC-1, go to SHOW and set `cnt`=0. Outputs in GAP: `an`=1111, `seg`=7F, `dp`=1.
- SHOW: `cnt` counts 0..DIGIT_CYC-1. At DIGIT_CYC-1, go to GAP, set `cnt`=0 and `idx`=`idx`+1 mod 4 (3 wraps to 0). Scan order is 0,1,2,3.
- SHOW outputs:
  - `an` = ~(1<<`idx`).
  - `seg` = glyph(`snap[4*idx+3 : 4*idx]`), or 7F if that digit is blanked.
  - `dp` = ~`snap_dp[idx]`. The decimal point is never blanked.
- Capture: on any edge where `state`=GAP, `idx`=0 and `cnt`=0, load `snap`←`data`, `snap_dp`←`dp_in`, `snap_lz`←`lz_blank`. On that same edge, `frame_start` is registered to 1; on every other edge it is registered to 0.
- Input changes between captures have no effect on the current frame.
- Leading-zero blanking (only when `snap_lz`=1): digit k∈{3,2,1} is blanked iff `snap` nibbles k..3 are all zero. Digit 0 is never blanked. Anode timing is unchanged by blanking.
- Glyphs, active-low hex, 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- Outputs are a pure decode of registered state; no combinational path from `data`, `dp_in` or `lz_blank` to any output.

## Timing
- Frame period = 4·(GAP_CYC+DIGIT_CYC) cycles. `frame_start` recurs with exactly this period.
- Reset release:
  - The first rising edge with `clr`=1 is a capture edge; `frame_start`=1 during the following cycle.
  - The GAP after capture lasts GAP_CYC cycles in total, counting the capture cycle. After it, digit 0 is lit for DIGIT_CYC cycles.
- At most one anode is low in any cycle. Every anode change (whether lighting or going dark) passes through at least GAP_CYC all-dark cycles.
- `clr` going low at any point (mid-SHOW, mid-GAP, or in the capture cycle) forces all reset values immediately, without waiting for a clock edge. After release, operation restarts from GAP/idx 0 with a fresh capture.
- Latency from `data` change to display: at most one frame period plus GAP_CYC cycles.

## Test plan
All scenarios use GAP_CYC=2, DIGIT_CYC=4 (frame = 24 cycles).
- **Reset hold:** hold `clr`=0 and toggle `data` → `an`=1111, `seg`=7F, `dp`=1, `frame_start`=0 throughout.
- **Basic scan:** `data`=16'h1234, `dp_in`=0, `lz_blank`=0, release `clr` → `frame_start` pulses in cycle 1, then:
  - 2 dark cycles, then `an`=1110 with `seg`=19 for 4 cycles;
  - 2 dark cycles, then `an`=1101 with `seg`=30;
  - 2 dark cycles, then `an`=1011 with `seg`=24;
  - 2 dark cycles, then `an`=0111 with `seg`=79;
  - `frame_start` pulses again 24 cycles after the first pulse.
- **Snapshot isolation:** change `data` to 16'hABCD while digit 1 is lit → the rest of that frame still shows 3, 2, 1. The next frame shows 21, 46, 03, 08 on digits 0..3.
- **Leading-zero blanking:** `lz_blank`=1, `data`=16'h0050 → digits 3 and 2 show `seg`=7F (their anodes still pulse low), digit 1 shows 12, digit 0 shows 40. With `data`=16'h0000, only digit 0 shows 40.
- **Decimal point:** `dp_in`=4'b0100 → `dp`=0 only while `an`=1011; `dp`=1 in every other cycle, including all GAP cycles.
- **Async reset mid-SHOW:** pulse `clr` low mid-cycle while digit 2 is lit → outputs reach their reset values before the next clock edge. After release, a new capture occurs, digit 0 is lit first, and the frame period is again 24 cycles.

Source files
------------

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scan driver for a common-anode display.
// The input word is snapshotted once per frame; every digit is preceded by a dark gap.
module seg7_scan #(
  parameter int DIGIT_CYC = 50000,
  parameter int GAP_CYC   = 500
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  input  logic        lz_blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int MAXC = (DIGIT_CYC > GAP_CYC) ? DIGIT_CYC : GAP_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYC - 1);

  typedef enum logic {GAP = 1'b0, SHOW = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [15:0]   snap;
  logic [3:0]    snap_dp;
  logic          snap_lz;
  logic          capture;
  logic [3:0]    blank;

  // Active-low hex glyphs, bit 0 = segment a.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // A digit is blanked only if it and every digit to its left are zero; digit 0 always shows.
  function automatic logic [3:0] lz_mask(input logic [15:0] s, input logic lz);
    logic [3:0] m;
    m[3] = lz && (s[15:12] == 4'h0);
    m[2] = m[3] && (s[11:8] == 4'h0);
    m[1] = m[2] && (s[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

  assign capture = (state == GAP) && (idx == 2'd0) && (cnt == '0);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= GAP;
      idx   <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt + CW'(1);
    case (state)
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
        end
      end
      SHOW: begin
        if (cnt == DIGIT_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
          idx_nxt   = idx + 2'd1;
        end
      end
      default: begin
        state_nxt = GAP;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Frame snapshot: inputs are sampled only at the start of the digit-0 gap.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      snap        <= 16'h0000;
      snap_dp     <= 4'h0;
      snap_lz     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= capture;
      if (capture) begin
        snap    <= data;
        snap_dp <= dp_in;
        snap_lz <= lz_blank;
      end
    end
  end

  assign blank = lz_mask(snap, snap_lz);

  always_comb begin
    an  = 4'b1111;
    seg = 7'h7F;
    dp  = 1'b1;
    if (state == SHOW) begin
      an  = ~(4'b0001 << idx);
      seg = blank[idx] ? 7'h7F : glyph(snap[{idx, 2'b00} +: 4]);
      dp  = ~snap_dp[idx];
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: a frame-position model checked every cycle, plus literal checkpoints.
module tb_seg7_scan;

  localparam int G = 2;
  localparam int D = 4;
  localparam int FRAME = 4 * (G + D);
  localparam logic [6:0] GLY [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  seg7_scan #(.DIGIT_CYC(D), .GAP_CYC(G)) dut (
    .clk(clk), .clr(clr), .data(data), .dp_in(dp_in), .lz_blank(lz_blank),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position within the frame, position 0 being the cycle whose closing edge captures.
  int          m_p    = 0;
  logic [15:0] m_snap = 16'h0;
  logic [3:0]  m_dp   = 4'h0;
  logic        m_lz   = 1'b0;
  logic        m_fs   = 1'b0;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_p    <= 0;
      m_snap <= 16'h0;
      m_dp   <= 4'h0;
      m_lz   <= 1'b0;
      m_fs   <= 1'b0;
    end else begin
      m_fs <= (m_p == 0);
      if (m_p == 0) begin
        m_snap <= data;
        m_dp   <= dp_in;
        m_lz   <= lz_blank;
      end
      m_p <= (m_p + 1) % FRAME;
    end
  end

  function automatic void model_out(input int p, input logic [15:0] s, input logic [3:0] d,
                                    input logic l, output logic [3:0] a, output logic [6:0] sg,
                                    output logic e_dp);
    int slot;
    int off;
    int nib;
    slot = p / (G + D);
    off  = p % (G + D);
    if (off < G) begin
      a = 4'hF; sg = 7'h7F; e_dp = 1'b1;
    end else begin
      a    = 4'hF & ~(4'b0001 << slot);
      nib  = (s >> (4 * slot)) & 16'hF;
      sg   = (l && slot > 0 && (s >> (4 * slot)) == 16'h0) ? 7'h7F : GLY[nib];
      e_dp = ~d[slot];
    end
  endfunction

  int ncyc = 0;
  int last_fs = -1;

  always @(negedge clk) begin
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    ncyc++;
    model_out(m_p, m_snap, m_dp, m_lz, ea, es, ed);
    chk("an", {28'h0, an}, {28'h0, ea});
    chk("seg", {25'h0, seg}, {25'h0, es});
    chk("dp", {31'h0, dp}, {31'h0, ed});
    chk("frame_start", {31'h0, frame_start}, {31'h0, m_fs});
    if (!clr) last_fs = -1;
    else if (frame_start) begin
      if (last_fs >= 0) chk("fs_period", ncyc - last_fs, FRAME);
      last_fs = ncyc;
    end
  end

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [3:0] ea, input logic [6:0] es, input logic ed);
    chk({name, "_an"}, {28'h0, an}, {28'h0, ea});
    chk({name, "_seg"}, {25'h0, seg}, {25'h0, es});
    chk({name, "_dp"}, {31'h0, dp}, {31'h0, ed});
  endtask

  initial begin
    clr = 1'b1; data = 16'h0; dp_in = 4'h0; lz_blank = 1'b0;
    #1 clr = 1'b0;
    repeat (4) begin
      @(negedge clk);
      data = data + 16'h1111;
    end
    lit("reset_hold", 4'hF, 7'h7F, 1'b1);
    chk("reset_fs", {31'h0, frame_start}, 32'h0);

    data = 16'h1234; dp_in = 4'h0; lz_blank = 1'b0;
    @(posedge clk); #2 clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("first_fs", {31'h0, frame_start}, 32'h1);
    lit("cap_gap", 4'hF, 7'h7F, 1'b1);
    adv(1);  lit("d0_4", 4'hE, 7'h19, 1'b1);
    adv(6);  lit("d1_3", 4'hD, 7'h30, 1'b1);
    data = 16'hABCD;
    adv(6);  lit("d2_2", 4'hB, 7'h24, 1'b1);
    adv(6);  lit("d3_1", 4'h7, 7'h79, 1'b1);
    adv(5);  chk("second_fs", {31'h0, frame_start}, 32'h1);
    adv(1);  lit("d0_D", 4'hE, 7'h21, 1'b1);
    adv(6);  lit("d1_C", 4'hD, 7'h46, 1'b1);
    adv(6);  lit("d2_B", 4'hB, 7'h03, 1'b1);
    adv(6);  lit("d3_A", 4'h7, 7'h08, 1'b1);
    lz_blank = 1'b1; data = 16'h0050;
    adv(6);  lit("lz_d0", 4'hE, 7'h40, 1'b1);
    adv(6);  lit("lz_d1", 4'hD, 7'h12, 1'b1);
    adv(6);  lit("lz_d2", 4'hB, 7'h7F, 1'b1);
    adv(6);  lit("lz_d3", 4'h7, 7'h7F, 1'b1);
    data = 16'h0000; dp_in = 4'b0100;
    adv(6);  lit("z_d0", 4'hE, 7'h40, 1'b1);
    adv(6);  lit("z_d1", 4'hD, 7'h7F, 1'b1);
    adv(4);  lit("dp_gap", 4'hF, 7'h7F, 1'b1);
    adv(3);  lit("dp_d2", 4'hB, 7'h7F, 1'b0);
    #2 clr = 1'b0;
    #1 lit("async_rst", 4'hF, 7'h7F, 1'b1);
    chk("async_fs", {31'h0, frame_start}, 32'h0);
    adv(2);
    @(posedge clk); #2 clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("restart_fs", {31'h0, frame_start}, 32'h1);
    adv(1);  lit("restart_d0", 4'hE, 7'h40, 1'b1);
    adv(30);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
